// File: rtl/ram_block_mover.sv
`default_nettype none
// ============================================================================
// Module   : ram_block_mover
// Block fill / block copy engine driving one RAM port (registered read).
// Optional macro RAM_BLOCK_MOVER_OVERLAP_EN: forward-overlapping copies run
// descending so the result matches memmove.
// Revision : 1.0
// ============================================================================
module ram_block_mover #(
   parameter int ADDRESS_WIDTH = 10,
   parameter int DATA_WIDTH    = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic                     mode,
   input  logic [ADDRESS_WIDTH-1:0] src_addr,
   input  logic [ADDRESS_WIDTH-1:0] dst_addr,
   input  logic [ADDRESS_WIDTH:0]   length,
   input  logic [DATA_WIDTH-1:0]    fill_data,
   input  logic                     abort,
   output logic                     busy,
   output logic                     done,
   output logic [ADDRESS_WIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0]    ram_data,
   output logic                     ram_wren,
   input  logic [DATA_WIDTH-1:0]    ram_q
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FILL    = 3'd1,
      S_COPY_RD = 3'd2,
      S_COPY_WR = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   localparam logic [ADDRESS_WIDTH-1:0] C_ONE     = ADDRESS_WIDTH'(1);
   localparam logic [ADDRESS_WIDTH:0]   C_CNT_ONE = (ADDRESS_WIDTH+1)'(1);

   state_t                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
   logic [ADDRESS_WIDTH:0]   cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]    fill_q, fill_d;
   logic                     desc_q, desc_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0]    data_q, data_d;
   logic                     wren_q, wren_d, busy_q, busy_d, done_q, done_d;
   logic                     copy_wr_q, copy_wr_d;
   logic                     overlap;

`ifdef RAM_BLOCK_MOVER_OVERLAP_EN
   logic [ADDRESS_WIDTH:0] src_ext, dst_ext;
   assign src_ext = {1'b0, src_addr};
   assign dst_ext = {1'b0, dst_addr};
   // Compared one bit wider so a range running past the top never wraps.
   assign overlap = mode && (src_ext < dst_ext) && (dst_ext < (src_ext + length));
`else
   assign overlap = 1'b0;
`endif

   function automatic logic [ADDRESS_WIDTH-1:0] step(input logic [ADDRESS_WIDTH-1:0] p,
                                                     input logic down);
      return down ? (p - C_ONE) : (p + C_ONE);
   endfunction

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      fill_d  = fill_q;
      desc_d  = desc_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               fill_d = fill_data;
               cnt_d  = length;
               desc_d = overlap;
               src_d  = overlap ? (src_addr + length[ADDRESS_WIDTH-1:0] - C_ONE) : src_addr;
               dst_d  = overlap ? (dst_addr + length[ADDRESS_WIDTH-1:0] - C_ONE) : dst_addr;
               if (length == '0)
                  state_d = S_DONE;
               else if (mode)
                  state_d = S_COPY_RD;
               else
                  state_d = S_FILL;
            end
         end
         S_FILL: begin
            dst_d = step(dst_q, desc_q);
            cnt_d = cnt_q - C_CNT_ONE;
            if (abort)
               state_d = S_IDLE;
            else if (cnt_q == C_CNT_ONE)
               state_d = S_DONE;
         end
         S_COPY_RD: begin
            state_d = abort ? S_IDLE : S_COPY_WR;
         end
         S_COPY_WR: begin
            src_d = step(src_q, desc_q);
            dst_d = step(dst_q, desc_q);
            cnt_d = cnt_q - C_CNT_ONE;
            if (abort)
               state_d = S_IDLE;
            else if (cnt_q == C_CNT_ONE)
               state_d = S_DONE;
            else
               state_d = S_COPY_RD;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Port outputs are precomputed from the next state so they are pure flops.
   always_comb begin
      addr_d    = '0;
      data_d    = '0;
      wren_d    = 1'b0;
      busy_d    = 1'b0;
      copy_wr_d = 1'b0;
      done_d    = (state_d == S_DONE);
      case (state_d)
         S_FILL: begin
            addr_d = dst_d;
            data_d = fill_d;
            wren_d = 1'b1;
            busy_d = 1'b1;
         end
         S_COPY_RD: begin
            addr_d = src_d;
            busy_d = 1'b1;
         end
         S_COPY_WR: begin
            addr_d    = dst_d;
            wren_d    = 1'b1;
            busy_d    = 1'b1;
            copy_wr_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         cnt_q     <= '0;
         fill_q    <= '0;
         desc_q    <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         wren_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         copy_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         cnt_q     <= cnt_d;
         fill_q    <= fill_d;
         desc_q    <= desc_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         wren_q    <= wren_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         copy_wr_q <= copy_wr_d;
      end
   end

   // Read data only arrives in the write cycle, so copy data bypasses the flop.
   assign ram_data    = copy_wr_q ? ram_q : data_q;
   assign ram_address = addr_q;
   assign ram_wren    = wren_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_block_mover.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_block_mover
// Self-checking bench: RAM model plus array-level reference of fill/copy.
// Revision : 1.0
// ============================================================================
module tb_ram_block_mover;
   localparam int AW    = 10;
   localparam int DW    = 8;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0, mode = 1'b0, abort = 1'b0;
   logic [AW-1:0] src_addr = '0, dst_addr = '0;
   logic [AW:0]   length = '0;
   logic [DW-1:0] fill_data = '0;
   logic          busy, done, ram_wren;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_data, ram_q;

   logic [DW-1:0] mem     [DEPTH];
   logic [DW-1:0] exp_mem [DEPTH];
   logic          ld_we = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [DW-1:0] ld_data = '0;

   int n_cmp = 0;
   int n_err = 0;
   int done_cyc, done_cnt, busy_cnt, busy_last, wren_cnt;
   int            wr_cyc_q[$];
   logic [AW-1:0] wr_addr_q[$];
   logic [DW-1:0] wr_data_q[$];

   always #5 clk = ~clk;

   ram_block_mover #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
      .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
      .fill_data(fill_data), .abort(abort), .busy(busy), .done(done),
      .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
      .ram_q(ram_q)
   );

   always @(posedge clk) begin
      if (ram_wren)   mem[ram_address] <= ram_data;
      else if (ld_we) mem[ld_addr]     <= ld_data;
      ram_q <= mem[ram_address];
   end

   function automatic int mem_diff();
      int n = 0;
      for (int a = 0; a < DEPTH; a++)
         if (mem[a] !== exp_mem[a]) n++;
      return n;
   endfunction

   // Reference: word i of a command moves to dst+i (or dst+len-1-i when descending).
   task automatic apply_model(input logic m, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                              input int len, input logic [DW-1:0] fill, input int nw);
      bit desc = 1'b0;
`ifdef RAM_BLOCK_MOVER_OVERLAP_EN
      if (m && (int'(src) < int'(dst)) && (int'(dst) < int'(src) + len)) desc = 1'b1;
`endif
      for (int i = 0; i < nw; i++) begin
         int k = desc ? (len - 1 - i) : i;
         logic [AW-1:0] da = AW'(int'(dst) + k);
         logic [AW-1:0] sa = AW'(int'(src) + k);
         exp_mem[da] = m ? exp_mem[sa] : fill;
      end
   endtask

   task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
      ld_we = 1'b1; ld_addr = a; ld_data = d; exp_mem[a] = d;
      @(posedge clk); #1;
      ld_we = 1'b0;
   endtask

   task automatic load_all();
      for (int a = 0; a < DEPTH; a++) load_word(AW'(a), DW'($urandom));
   endtask

   task automatic run_cmd(input logic m, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                          input int len, input logic [DW-1:0] fill,
                          input int abort_at, input int restart_at);
      int limit = 2 * len + 6;
      mode = m; src_addr = src; dst_addr = dst; length = (AW+1)'(len);
      fill_data = fill; start = 1'b1;
      done_cyc = 0; done_cnt = 0; busy_cnt = 0; busy_last = 0; wren_cnt = 0;
      wr_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= limit; c++) begin
         if (busy) begin busy_cnt++; busy_last = c; end
         if (ram_wren) begin
            wren_cnt++;
            wr_cyc_q.push_back(c);
            wr_addr_q.push_back(ram_address);
            wr_data_q.push_back(ram_data);
         end
         if (done) begin done_cnt++; if (done_cyc == 0) done_cyc = c; end
         if (done_cyc != 0 && c > done_cyc + 1) break;
         if (abort_at > 0 && c > abort_at + 2) break;
         abort = (c == abort_at);
         if (c == restart_at) begin
            start = 1'b1; mode = ~m; length = (AW+1)'(3); dst_addr = dst + AW'(100);
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      abort = 1'b0; start = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (ram_wren !== 1'b0) begin n_err++; $display("FAIL reset_wren: got %b want 0", ram_wren); end
      n_cmp++; if (ram_address !== '0) begin n_err++; $display("FAIL reset_addr: got %h want 0", ram_address); end
      n_cmp++; if (ram_data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", ram_data); end
   endtask

   task automatic test_fill_wrap();
      run_cmd(1'b0, '0, AW'('h3FE), 4, 8'hA5, 0, 0);
      apply_model(1'b0, '0, AW'('h3FE), 4, 8'hA5, 4);
      n_cmp++; if (wr_addr_q.size() != 4) begin n_err++; $display("FAIL fill_wrap_count: got %0d want 4", wr_addr_q.size()); end
      for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
         logic [AW-1:0] ea = AW'('h3FE + i);
         n_cmp++;
         if (wr_addr_q[i] !== ea || wr_cyc_q[i] != i + 1 || wr_data_q[i] !== 8'hA5) begin
            n_err++;
            $display("FAIL fill_wrap_write%0d: got addr %h cyc %0d data %h want addr %h cyc %0d data a5",
                     i, wr_addr_q[i], wr_cyc_q[i], wr_data_q[i], ea, i + 1);
         end
      end
      n_cmp++; if (done_cyc != 5) begin n_err++; $display("FAIL fill_wrap_done: got cycle %0d want 5", done_cyc); end
      n_cmp++; if (busy_last != 4 || busy_cnt != 4) begin n_err++; $display("FAIL fill_wrap_busy: got last %0d count %0d want 4/4", busy_last, busy_cnt); end
      n_cmp++; if (mem_diff() != 0) begin n_err++; $display("FAIL fill_wrap_mem: got %0d bad words want 0", mem_diff()); end
   endtask

   task automatic test_copy();
      load_word(AW'('h10), 8'h11);
      load_word(AW'('h11), 8'h22);
      load_word(AW'('h12), 8'h33);
      run_cmd(1'b1, AW'('h10), AW'('h80), 3, 8'h00, 0, 0);
      apply_model(1'b1, AW'('h10), AW'('h80), 3, 8'h00, 3);
      n_cmp++;
      if (mem['h80] !== 8'h11 || mem['h81] !== 8'h22 || mem['h82] !== 8'h33) begin
         n_err++;
         $display("FAIL copy_data: got %h %h %h want 11 22 33", mem['h80], mem['h81], mem['h82]);
      end
      n_cmp++;
      if (wr_cyc_q.size() != 3 || wr_cyc_q[0] != 2 || wr_cyc_q[1] != 4 || wr_cyc_q[2] != 6) begin
         n_err++;
         $display("FAIL copy_wren_cycles: got %0d writes (first %0d) want cycles 2,4,6",
                  wr_cyc_q.size(), (wr_cyc_q.size() > 0) ? wr_cyc_q[0] : -1);
      end
      n_cmp++; if (done_cyc != 7) begin n_err++; $display("FAIL copy_done: got cycle %0d want 7", done_cyc); end
      n_cmp++; if (mem_diff() != 0) begin n_err++; $display("FAIL copy_mem: got %0d bad words want 0", mem_diff()); end
   endtask

   task automatic test_zero_length();
      run_cmd(1'b0, '0, AW'('h55), 0, 8'h77, 0, 0);
      n_cmp++; if (wren_cnt != 0) begin n_err++; $display("FAIL zero_wren: got %0d writes want 0", wren_cnt); end
      n_cmp++; if (busy_cnt != 0) begin n_err++; $display("FAIL zero_busy: got %0d busy cycles want 0", busy_cnt); end
      n_cmp++; if (done_cyc != 1) begin n_err++; $display("FAIL zero_done: got cycle %0d want 1", done_cyc); end
   endtask

   task automatic test_abort();
      logic [DW-1:0] f = DW'($urandom);
      run_cmd(1'b0, '0, '0, 16, f, 5, 0);
      apply_model(1'b0, '0, '0, 16, f, 5);
      n_cmp++; if (wren_cnt != 5) begin n_err++; $display("FAIL abort_writes: got %0d want 5", wren_cnt); end
      n_cmp++; if (done_cnt != 0) begin n_err++; $display("FAIL abort_done: got %0d pulses want 0", done_cnt); end
      n_cmp++; if (busy_last != 5) begin n_err++; $display("FAIL abort_idle: got last busy cycle %0d want 5", busy_last); end
      n_cmp++; if (mem_diff() != 0) begin n_err++; $display("FAIL abort_mem: got %0d bad words want 0", mem_diff()); end
      run_cmd(1'b0, '0, AW'('h40), 1, 8'h3C, 0, 0);
      apply_model(1'b0, '0, AW'('h40), 1, 8'h3C, 1);
      n_cmp++; if (done_cyc != 2) begin n_err++; $display("FAIL abort_restart: got done cycle %0d want 2", done_cyc); end
   endtask

   task automatic test_overlap();
      logic [DW-1:0] e [4];
`ifdef RAM_BLOCK_MOVER_OVERLAP_EN
      e = '{8'd1, 8'd2, 8'd3, 8'd4};
`else
      e = '{8'd1, 8'd1, 8'd1, 8'd1};
`endif
      for (int i = 0; i < 4; i++) load_word(AW'(i), DW'(i + 1));
      run_cmd(1'b1, '0, AW'(1), 4, 8'h00, 0, 0);
      apply_model(1'b1, '0, AW'(1), 4, 8'h00, 4);
      n_cmp++;
      if (mem[1] !== e[0] || mem[2] !== e[1] || mem[3] !== e[2] || mem[4] !== e[3]) begin
         n_err++;
         $display("FAIL overlap_data: got %0d %0d %0d %0d want %0d %0d %0d %0d",
                  mem[1], mem[2], mem[3], mem[4], e[0], e[1], e[2], e[3]);
      end
      n_cmp++; if (done_cyc != 9) begin n_err++; $display("FAIL overlap_done: got cycle %0d want 9", done_cyc); end
   endtask

   task automatic test_ignore_start();
      run_cmd(1'b0, '0, AW'('h120), 6, 8'h5A, 0, 2);
      apply_model(1'b0, '0, AW'('h120), 6, 8'h5A, 6);
      n_cmp++; if (done_cyc != 7 || done_cnt != 1) begin n_err++; $display("FAIL ignore_done: got cycle %0d count %0d want 7/1", done_cyc, done_cnt); end
      n_cmp++; if (wren_cnt != 6 || busy_cnt != 6) begin n_err++; $display("FAIL ignore_counts: got wren %0d busy %0d want 6/6", wren_cnt, busy_cnt); end
      n_cmp++; if (mem_diff() != 0) begin n_err++; $display("FAIL ignore_mem: got %0d bad words want 0", mem_diff()); end
   endtask

   task automatic test_reset_mid();
      int bad = 0;
      mode = 1'b1; src_addr = AW'('h200); dst_addr = AW'('h300); length = (AW+1)'(10); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, done, ram_wren} !== 3'b000 || ram_address !== '0 || ram_data !== '0) begin
         n_err++;
         $display("FAIL midreset_outputs: got busy %b done %b wren %b addr %h data %h want all 0",
                  busy, done, ram_wren, ram_address, ram_data);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         if (busy !== 1'b0 || done !== 1'b0 || ram_wren !== 1'b0) bad++;
      end
      n_cmp++; if (bad != 0) begin n_err++; $display("FAIL midreset_idle: got %0d active cycles want 0", bad); end
      for (int a = 0; a < DEPTH; a++) exp_mem[a] = mem[a];
      run_cmd(1'b0, '0, AW'('h3A0), 2, 8'hC3, 0, 0);
      apply_model(1'b0, '0, AW'('h3A0), 2, 8'hC3, 2);
      n_cmp++; if (done_cyc != 3) begin n_err++; $display("FAIL midreset_restart: got done cycle %0d want 3", done_cyc); end
      n_cmp++; if (mem_diff() != 0) begin n_err++; $display("FAIL midreset_mem: got %0d bad words want 0", mem_diff()); end
   endtask

   task automatic test_random();
      for (int t = 0; t < 25; t++) begin
         logic          m   = 1'($urandom);
         int            len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40));
         logic [AW-1:0] src = AW'($urandom);
         logic [AW-1:0] dst = ($urandom_range(0, 1) == 1) ? AW'(int'(src) + int'($urandom_range(0, len + 1)))
                                                           : AW'($urandom);
         logic [DW-1:0] f   = DW'($urandom);
         int exp_done = (len == 0) ? 1 : (m ? 2 * len + 1 : len + 1);
         int exp_busy = m ? 2 * len : len;
         run_cmd(m, src, dst, len, f, 0, 0);
         apply_model(m, src, dst, len, f, len);
         n_cmp++; if (done_cyc != exp_done) begin n_err++; $display("FAIL rand%0d_done: got cycle %0d want %0d", t, done_cyc, exp_done); end
         n_cmp++; if (busy_cnt != exp_busy) begin n_err++; $display("FAIL rand%0d_busy: got %0d want %0d", t, busy_cnt, exp_busy); end
         n_cmp++; if (wren_cnt != len) begin n_err++; $display("FAIL rand%0d_wren: got %0d want %0d", t, wren_cnt, len); end
         n_cmp++; if (mem_diff() != 0) begin n_err++; $display("FAIL rand%0d_mem: got %0d bad words want 0", t, mem_diff()); end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      load_all();
      test_fill_wrap();
      test_copy();
      test_zero_length();
      test_abort();
      test_overlap();
      test_ignore_start();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
